// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares the single RAM port between instruction fetch (I) and data access (D).
// Only one transaction is granted at a time. Its address, store data and
// operation are latched when it is granted. D requests have priority, but I is
// forced through after MAX_DSTREAK consecutive D completions that happen while
// I is waiting. A transaction ends on ACCESS, on ERROR, or after TIMEOUT cycles
// in a grant state.
//
// Ports
//   CLK, nRST                  clock (rising edge), async active-low reset
//   iREN, iaddr                instruction read request and word address
//   iwait, iload               I stall and I read data
//   dREN, dWEN, daddr, dstore  data request (a write wins over a read), address, write data
//   dwait, dload               D stall and D read data
//   ramREN, ramWEN             RAM strobes, driven from the latched operation
//   ramaddr, ramstore          latched RAM address and write data
//   ramload, ramstate          RAM read data and status (00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR)
//   bus_err                    one-cycle pulse on an ERROR or timeout completion
//
// state  | meaning
// IDLE   | no transaction; picks the next requester
// DGRANT | data transaction owns the RAM
// IGRANT | instruction fetch owns the RAM
module memory_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        bus_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int SW = $clog2(MAX_DSTREAK + 1);

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     store_q, store_d;
    logic            wr_q, wr_d;

    logic granted, ram_ok, ram_err, tmo, done, d_req, i_forced;

    assign d_req    = dREN | dWEN;
    assign granted  = (state_q != IDLE);
    assign ram_ok   = (ramstate == 2'b10);
    assign ram_err  = (ramstate == 2'b11);
    assign tmo      = (tcnt_q == TW'(TIMEOUT - 1)) && !ram_ok;
    assign done     = granted && (ram_ok || ram_err || tmo);
    assign i_forced = iREN && (streak_q == SW'(MAX_DSTREAK));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            tcnt_q   <= '0;
            streak_q <= '0;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wr_d     = wr_q;
        case (state_q)
            IDLE: begin
                if (d_req && !i_forced) begin
                    state_d = DGRANT;
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                end else if (iREN) begin
                    state_d  = IGRANT;
                    addr_d   = iaddr;
                    store_d  = '0;
                    wr_d     = 1'b0;
                    streak_d = '0;
                end
            end
            DGRANT, IGRANT: begin
                if (done) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                    if (state_q == DGRANT) begin
                        // Count D wins only while I is actually waiting.
                        if (!iREN)
                            streak_d = '0;
                        else if (streak_q != SW'(MAX_DSTREAK))
                            streak_d = streak_q + SW'(1);
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ramREN   = granted && !wr_q;
    assign ramWEN   = granted && wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    // Waits are combinational; gating with nRST keeps every output low while reset is held.
    assign iwait   = nRST && iREN  && !((state_q == IGRANT) && done);
    assign dwait   = nRST && d_req && !((state_q == DGRANT) && done);
    assign iload   = ((state_q == IGRANT) && done && ram_ok) ? ramload : '0;
    assign dload   = ((state_q == DGRANT) && done && ram_ok) ? ramload : '0;
    assign bus_err = done && !ram_ok;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
    localparam int MAXD = 4;
    localparam int TMO  = 64;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]  ramstate = 2'b00;
    logic        iwait, dwait, ramREN, ramWEN, bus_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    memory_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Transaction-level reference: who owns the RAM, what was latched, how long it has waited.
    int          m_owner;   // 0 none, 1 data, 2 instruction
    int          m_age;
    int          m_streak;
    logic        m_wr;
    logic [31:0] m_addr, m_store;
    logic        m_i_done, m_d_done;
    int          n_dcomp, n_icomp;
    string       order;

    task automatic model_reset();
        m_owner = 0; m_age = 0; m_streak = 0; m_wr = 1'b0;
        m_addr = '0; m_store = '0; m_i_done = 1'b0; m_d_done = 1'b0;
    endtask

    task automatic check_and_advance();
        logic busy, fin, ok, dreq;
        busy = (m_owner != 0);
        fin  = busy && (ramstate == 2'b10 || ramstate == 2'b11 || m_age == TMO - 1);
        ok   = fin && (ramstate == 2'b10);
        dreq = dREN | dWEN;
        check_val("ramREN", ramREN, busy && !m_wr);
        check_val("ramWEN", ramWEN, busy && m_wr);
        if (busy) check_val("ramaddr", ramaddr, m_addr);
        if (busy && m_wr) check_val("ramstore", ramstore, m_store);
        check_val("iwait", iwait, iREN && !(m_owner == 2 && fin));
        check_val("dwait", dwait, dreq && !(m_owner == 1 && fin));
        check_val("iload", iload, (m_owner == 2 && ok) ? ramload : 32'h0);
        check_val("dload", dload, (m_owner == 1 && ok) ? ramload : 32'h0);
        check_val("bus_err", bus_err, fin && !ok);
        m_i_done = (m_owner == 2) && fin;
        m_d_done = (m_owner == 1) && fin;
        if (busy) begin
            if (fin) begin
                if (m_owner == 1) begin
                    m_streak = iREN ? ((m_streak < MAXD) ? m_streak + 1 : MAXD) : 0;
                    n_dcomp++;
                    if (order.len() < 20) order = {order, "D"};
                end else begin
                    n_icomp++;
                    if (order.len() < 20) order = {order, "I"};
                end
                m_owner = 0;
                m_age   = 0;
            end else begin
                m_age++;
            end
        end else if (dreq && !(iREN && m_streak == MAXD)) begin
            m_owner = 1; m_wr = dWEN; m_addr = daddr; m_store = dstore;
        end else if (iREN) begin
            m_owner = 2; m_wr = 1'b0; m_addr = iaddr; m_store = '0; m_streak = 0;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        #1;
        check_and_advance();
        @(negedge CLK);
    endtask

    initial begin
        model_reset();
        n_dcomp = 0; n_icomp = 0; order = "";
        repeat (2) @(negedge CLK);
        #1;
        check_val("rst_ramREN", ramREN, 0);
        check_val("rst_ramWEN", ramWEN, 0);
        check_val("rst_ramaddr", ramaddr, 0);
        check_val("rst_busErr", bus_err, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // Instruction fetch: 3 BUSY cycles then ACCESS.
        iREN = 1'b1; iaddr = 32'h40;
        for (int k = 0; k < 5; k++) begin
            ramstate = (k == 4) ? 2'b10 : (k == 0 ? 2'b00 : 2'b01);
            ramload  = 32'h1234_5678;
            cycle();
        end
        check_val("lat_i_done", n_icomp, 1);
        iREN = 1'b0; ramstate = 2'b00;
        cycle();

        // Simultaneous write and fetch: D first with latched data, then I.
        order = "";
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hCAFE_F00D; iREN = 1'b1; iaddr = 32'h44;
        for (int k = 0; k < 8; k++) begin
            ramstate = (k % 2 == 1) ? 2'b10 : 2'b01;
            daddr = 32'h200; dstore = 32'h0;
            cycle();
            if (m_d_done) dWEN = 1'b0;
            if (m_i_done) iREN = 1'b0;
        end
        check_val("wr_then_i_order", (order == "DI") ? 1 : 0, 1);
        iREN = 1'b0; dWEN = 1'b0;

        // D held with I pending: DDDDI pattern.
        order = "";
        dREN = 1'b1; iREN = 1'b1; ramstate = 2'b10;
        for (int k = 0; k < 20; k++) begin
            daddr = $urandom; iaddr = $urandom; ramload = $urandom;
            cycle();
        end
        check_val("streak_order", (order == "DDDDIDDDDI") ? 1 : 0, 1);
        dREN = 1'b0; iREN = 1'b0;
        cycle();

        // Stuck BUSY on a D read: timeout abort.
        dREN = 1'b1; daddr = 32'h300; ramstate = 2'b01;
        for (int k = 0; k < 70; k++) begin
            cycle();
            if (m_d_done) dREN = 1'b0;
        end
        dREN = 1'b0;

        // ERROR on an I fetch.
        iREN = 1'b1; iaddr = 32'h80; ramstate = 2'b00;
        cycle();
        ramstate = 2'b11;
        cycle();
        iREN = 1'b0; ramstate = 2'b00;
        cycle();

        // Reset while a D write is in progress.
        dWEN = 1'b1; daddr = 32'h500; dstore = 32'h55; ramstate = 2'b01;
        repeat (3) cycle();
        #2;
        nRST = 1'b0;
        #1;
        check_val("arst_ramWEN", ramWEN, 0);
        check_val("arst_dwait", dwait, 0);
        check_val("arst_ramaddr", ramaddr, 0);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        iREN = 1'b1; iaddr = 32'h600;
        for (int k = 0; k < 6; k++) begin
            ramstate = (k == 2 || k == 5) ? 2'b10 : 2'b01;
            cycle();
            if (m_d_done) dWEN = 1'b0;
            if (m_i_done) iREN = 1'b0;
        end
        iREN = 1'b0; dWEN = 1'b0;

        // Random traffic, including mid-grant drops and address changes.
        for (int k = 0; k < 3000; k++) begin
            int r;
            if (m_i_done && $urandom_range(9) < 7) iREN = 1'b0;
            else if (!iREN && $urandom_range(9) < 3) iREN = 1'b1;
            else if ($urandom_range(99) < 3) iREN = ~iREN;
            if (m_d_done && $urandom_range(9) < 7) begin
                dREN = 1'b0; dWEN = 1'b0;
            end else if (!(dREN | dWEN) && $urandom_range(9) < 3) begin
                r = $urandom_range(3);
                dREN = (r != 1); dWEN = (r != 0);
            end else if ($urandom_range(99) < 3) begin
                dREN = 1'b0; dWEN = 1'b0;
            end
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = $urandom_range(99);
            ramstate = (r < 50) ? 2'b01 : (r < 85) ? 2'b10 : (r < 95) ? 2'b11 : 2'b00;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
